// File: rtl/fp_mult_pipe.sv
// Pipelined floating-point multiplier with configurable exponent/mantissa widths,
// round-to-nearest-even, flush-to-zero, canonical NaN and valid/ready backpressure.
module fp_mult_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_x,
    input  logic [EXP_W+MAN_W:0] in_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_result,
    output logic                 out_inf,
    output logic                 out_nan,
    output logic                 out_zero,
    output logic                 out_overflow,
    output logic                 out_underflow
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned MW   = MAN_W + 1;
    localparam int unsigned PW   = 2 * MAN_W + 2;
    localparam int unsigned BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int unsigned EMAX = 2 ** EXP_W - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Whole pipe advances unless the output register holds an unaccepted result
    logic w_adv;
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    logic           r_v0, r_s1_v, r_s2_v;
    logic [W-1:0]   r_x, r_y;
    logic           r_s1_sign, r_s1_nan, r_s1_inf, r_s1_zero;
    logic [EW-1:0]  r_s1_e;
    logic [PW-1:0]  r_s1_prod;
    logic           r_s2_sign, r_s2_nan, r_s2_inf, r_s2_zero;
    logic [EW-1:0]  r_s2_e;
    logic [MAN_W-1:0] r_s2_man;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v0   <= 1'b0;
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
        end else if (w_adv) begin
            r_v0   <= in_valid;
            r_s1_v <= r_v0;
            r_s2_v <= r_s1_v;
        end
    end

    // S1: unpack, classify, exponent sum and mantissa product
    logic [EXP_W-1:0] w_ex, w_ey;
    logic [MAN_W-1:0] w_mx, w_my;
    logic             w_x_zero, w_y_zero, w_x_inf, w_y_inf, w_x_nan, w_y_nan;
    logic [EW-1:0]    w_s1_e;
    logic [PW-1:0]    w_s1_prod;

    assign w_ex      = r_x[W-2 -: EXP_W];
    assign w_ey      = r_y[W-2 -: EXP_W];
    assign w_mx      = r_x[MAN_W-1:0];
    assign w_my      = r_y[MAN_W-1:0];
    assign w_x_zero  = (w_ex == '0);
    assign w_y_zero  = (w_ey == '0);
    assign w_x_inf   = (w_ex == '1) && (w_mx == '0);
    assign w_y_inf   = (w_ey == '1) && (w_my == '0);
    assign w_x_nan   = (w_ex == '1) && (w_mx != '0);
    assign w_y_nan   = (w_ey == '1) && (w_my != '0);
    assign w_s1_e    = EW'(w_ex) + EW'(w_ey) - EW'(BIAS);
    assign w_s1_prod = PW'({1'b1, w_mx}) * PW'({1'b1, w_my});

    // S2: normalise so the leading one sits just above the stored field, then RNE
    logic [PW-2:0]  w_norm;
    logic [EW-1:0]  w_e_n, w_e_r;
    logic           w_guard, w_sticky, w_lsb, w_rnd;
    logic [MW-1:0]  w_man_r;

    assign w_norm   = r_s1_prod[PW-1] ? r_s1_prod[PW-2:0] : {r_s1_prod[PW-3:0], 1'b0};
    assign w_e_n    = r_s1_e + EW'(r_s1_prod[PW-1]);
    assign w_lsb    = w_norm[MAN_W+1];
    assign w_guard  = w_norm[MAN_W];
    assign w_sticky = |w_norm[MAN_W-1:0];
    assign w_rnd    = w_guard & (w_sticky | w_lsb);
    assign w_man_r  = {1'b0, w_norm[PW-2 -: MAN_W]} + MW'(w_rnd);
    assign w_e_r    = w_e_n + EW'(w_man_r[MAN_W]);

    always_ff @(posedge clk) begin
        if (w_adv) begin
            if (in_valid) begin
                r_x <= in_x;
                r_y <= in_y;
            end
            if (r_v0) begin
                r_s1_sign <= r_x[W-1] ^ r_y[W-1];
                r_s1_nan  <= w_x_nan | w_y_nan | (w_x_inf & w_y_zero) | (w_y_inf & w_x_zero);
                r_s1_inf  <= w_x_inf | w_y_inf;
                r_s1_zero <= w_x_zero | w_y_zero;
                r_s1_e    <= w_s1_e;
                r_s1_prod <= w_s1_prod;
            end
            if (r_s1_v) begin
                r_s2_sign <= r_s1_sign;
                r_s2_nan  <= r_s1_nan;
                r_s2_inf  <= r_s1_inf;
                r_s2_zero <= r_s1_zero;
                r_s2_e    <= w_e_r;
                r_s2_man  <= w_man_r[MAN_W-1:0];
            end
        end
    end

    // S3: priority select of the final result and flags
    logic signed [EW-1:0] w_e_s;
    logic [W-1:0]         w_res;
    logic                 w_inf, w_nan, w_zero, w_ovf, w_unf;

    assign w_e_s = r_s2_e;

    always_comb begin
        w_res  = {r_s2_sign, r_s2_e[EXP_W-1:0], r_s2_man};
        w_inf  = 1'b0;
        w_nan  = 1'b0;
        w_zero = 1'b0;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        if (r_s2_nan) begin
            w_res = QNAN;
            w_nan = 1'b1;
        end else if (r_s2_inf) begin
            w_res = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_inf = 1'b1;
        end else if (r_s2_zero) begin
            w_res  = {r_s2_sign, {(W-1){1'b0}}};
            w_zero = 1'b1;
        end else if (w_e_s >= $signed(EW'(EMAX))) begin
            w_res = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_inf = 1'b1;
            w_ovf = 1'b1;
        end else if (w_e_s <= $signed(EW'(0))) begin
            w_res  = {r_s2_sign, {(W-1){1'b0}}};
            w_zero = 1'b1;
            w_unf  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_inf       <= 1'b0;
            out_nan       <= 1'b0;
            out_zero      <= 1'b0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else if (w_adv) begin
            out_valid <= r_s2_v;
            if (r_s2_v) begin
                out_result    <= w_res;
                out_inf       <= w_inf;
                out_nan       <= w_nan;
                out_zero      <= w_zero;
                out_overflow  <= w_ovf;
                out_underflow <= w_unf;
            end
        end
    end
endmodule
